dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter DM_WORDS, default 3072, meaning DM depth in words; addresses at or above DM_WORDS*4 are out of range.
REQ-002 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports mN_req  input  1  requester N (N=0,1) access request.
REQ-005 The block SHALL have ports mN_we  input  1  1=store, 0=load.
REQ-006 The block SHALL have ports mN_addr  input  32  byte address.
REQ-007 The block SHALL have ports mN_wd  input  32  store data, right-aligned.
REQ-008 The block SHALL have ports mN_type  input  2  access width: 00 word, 01 byte, 10 half.
REQ-009 The block SHALL have ports mN_gnt  output  1  one-cycle request-accepted pulse.
REQ-010 The block SHALL have ports mN_rvalid  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have ports mN_rdata  output  32  load result, valid with mN_rvalid.
REQ-012 The block SHALL have ports mN_err  output  1  misaligned or out-of-range access, valid with mN_rvalid.
REQ-013 The block SHALL have ports dm_we  output  1, dm_addr  output  32, dm_wd  output  32, dm_type  output  2  single DM port drive.
REQ-014 The block SHALL have port dm_rd  input  32  DM combinational read data, already width-extracted and sign-extended.

Function
REQ-015 The block SHALL implement states IDLE, ACCESS and RESP.
REQ-016 In IDLE with any mN_req=1, the block SHALL pulse the winner's mN_gnt (combinational), latch its we/addr/wd/type/id, and go to ACCESS.
REQ-017 In ACCESS, the block SHALL drive dm_addr, dm_wd and dm_type from the latch, assert dm_we=latched we only if the access is legal, capture dm_rd, and go to RESP.
REQ-018 In RESP, the block SHALL pulse the owner's mN_rvalid with the captured rdata (0 for stores) and err, then return to IDLE.
REQ-019 Latency SHALL be fixed: gnt in cycle T, DM access in T+1, rvalid in T+2; at most one access per 3 cycles.
REQ-020 An access SHALL be illegal when half with addr[0]=1, word with addr[1:0]!=0, or addr>=DM_WORDS*4; illegal accesses SHALL keep dm_we=0 and return err=1 with rdata=0.
REQ-021 A requester SHALL hold mN_req and its payload until gnt; deasserting before gnt withdraws the request with no side effect.
REQ-022 Requests seen in ACCESS or RESP SHALL be ignored; no gnt issues outside IDLE.
REQ-023 Outside ACCESS, dm_we SHALL be 0; dm_addr, dm_wd and dm_type SHALL be 0.
REQ-024 With both mN_req=1 in IDLE, the winner SHALL follow REQ-033 / REQ-034.

Reset
REQ-025 On reset, the block SHALL enter IDLE and drive all gnt, rvalid, err, rdata and dm_* outputs to 0.
REQ-026 On reset, the RR pointer SHALL favour m0.
REQ-027 Reset asserted in ACCESS SHALL force dm_we=0 in that cycle, so no write commits and no rvalid is issued.
REQ-028 An in-flight access aborted by reset SHALL be lost; requesters re-request.

Configuration
REQ-029 Macro DM_ARB_RR_EN SHALL select arbitration.
REQ-030 With DM_ARB_RR_EN defined, the last-granted requester SHALL have lower priority on the next simultaneous request.
REQ-031 Without DM_ARB_RR_EN, m0 SHALL always win and the pointer SHALL be absent.
REQ-032 The block SHALL behave identically under both settings when requests do not collide.
REQ-033 With DM_ARB_RR_EN defined, collisions SHALL resolve by the pointer; it updates only on gnt.
REQ-034 Without DM_ARB_RR_EN, collisions SHALL resolve to m0.

Structure
REQ-035 Package dm_arb_pkg SHALL hold the width encodings (WORD=2'b00, BYTE=2'b01, HALF=2'b10) and the state encoding.
REQ-036 A sub-module dm_arb_pick SHALL be instantiated to hold the two-way priority pick and the RR pointer update.

Verification
REQ-037 Bench: m0 store word 0x12345678 to 0x10 at T -> m0_gnt at T, dm_we=1 with addr 0x10 at T+1, m0_rvalid at T+2 with err=0.
REQ-038 Bench: m0 and m1 loads both held from T under DM_ARB_RR_EN -> m0 granted at T, m1 at T+3, m0 at T+6 if m0 re-requests.
REQ-039 Bench: the same colliding loads without DM_ARB_RR_EN -> m0 granted at every opportunity while it requests.
REQ-040 Bench: m1 half store to 0x13 -> dm_we stays 0, m1_rvalid=1 with m1_err=1 and rdata=0.
REQ-041 Bench: m0 load to 0x3000 with DM_WORDS=3072 -> err=1 and no DM write.
REQ-042 Bench: reset asserted in the ACCESS cycle of a store -> dm_we=0, no rvalid, state IDLE on the next cycle.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared encodings for the two-requester data-memory arbiter.
package dm_arb_pkg;

  localparam logic [1:0] WORD = 2'b00;
  localparam logic [1:0] BYTE = 2'b01;
  localparam logic [1:0] HALF = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  typ;
    logic        id;
  } acc_t;

  // The reserved width code 2'b11 is treated as an illegal access.
  function automatic logic access_legal(input logic [31:0] addr,
                                        input logic [1:0]  typ,
                                        input logic [31:0] limit);
    logic ok;
    ok = (addr < limit);
    case (typ)
      WORD:    if (addr[1:0] != 2'b00) ok = 1'b0;
      HALF:    if (addr[0]) ok = 1'b0;
      BYTE:    ok = ok;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Two-way grant pick; with DM_ARB_RR_EN a round-robin pointer demotes the last
// winner, otherwise requester 0 always has priority.
module dm_arb_pick (
`ifdef DM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

`ifdef DM_ARB_RR_EN
  // prio1_q set means requester 1 wins the next collision.
  logic prio1_q, prio1_d;
  logic win1;

  always_comb begin
    win1    = req1_i & (~req0_i | prio1_q);
    gnt1_o  = en_i & win1;
    gnt0_o  = en_i & req0_i & ~win1;
    prio1_d = prio1_q;
    if (gnt0_o)      prio1_d = 1'b1;
    else if (gnt1_o) prio1_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) prio1_q <= 1'b0;
    else       prio1_q <= prio1_d;
  end
`else
  assign gnt0_o = en_i & req0_i;
  assign gnt1_o = en_i & req1_i & ~req0_i;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates two requesters onto one DM port: gnt at T, DM access at T+1, rvalid at T+2.
// DM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed m0 priority.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [1:0]  m0_type,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [1:0]  m1_type,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [1:0]  dm_type,
  input  logic [31:0] dm_rd
);

  localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS * 4);

  state_t      state_q, state_d;
  acc_t        acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        pick_en, g0, g1, legal, resp;

  assign pick_en = (state_q == IDLE) & ~reset;
  assign legal   = access_legal(acc_q.addr, acc_q.typ, DM_LIMIT);

  dm_arb_pick u_pick (
`ifdef DM_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .en_i   (pick_en),
    .req0_i (m0_req),
    .req1_i (m1_req),
    .gnt0_o (g0),
    .gnt1_o (g1)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_wd   = '0;
    dm_type = '0;
    case (state_q)
      IDLE: begin
        if (g0 | g1) begin
          acc_d.we   = g1 ? m1_we   : m0_we;
          acc_d.addr = g1 ? m1_addr : m0_addr;
          acc_d.wd   = g1 ? m1_wd   : m0_wd;
          acc_d.typ  = g1 ? m1_type : m0_type;
          acc_d.id   = g1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        dm_addr = acc_q.addr;
        dm_wd   = acc_q.wd;
        dm_type = acc_q.typ;
        dm_we   = acc_q.we & legal;
        rdata_d = (legal & ~acc_q.we) ? dm_rd : 32'h0;
        err_d   = ~legal;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so the DM port must be silenced combinationally
    // to stop a store committing on the reset edge.
    if (reset) begin
      dm_we   = 1'b0;
      dm_addr = '0;
      dm_wd   = '0;
      dm_type = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp      = (state_q == RESP) & ~reset;
  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = resp & ~acc_q.id;
  assign m1_rvalid = resp & acc_q.id;
  assign m0_rdata  = m0_rvalid ? rdata_q : 32'h0;
  assign m1_rdata  = m1_rvalid ? rdata_q : 32'h0;
  assign m0_err    = m0_rvalid & err_q;
  assign m1_err    = m1_rvalid & err_q;

endmodule
